// File: rtl/dnn_collect_pkg.sv
// Shared definitions for the DNN frame collector: default widths, the
// two-state VAD hangover encoding and the score saturation helper.
package dnn_collect_pkg;

  localparam int DNN_IN_W    = 22;
  localparam int DNN_VEC_W   = 11;
  localparam int DNN_NUM_OUT = 60;

  localparam logic [0:0] VAD_IDLE   = 1'b0;
  localparam logic [0:0] VAD_ACTIVE = 1'b1;

  // Clamp a signed value (up to 32 bits) into the signed range of vec_w bits.
  // The result is returned sign-extended; callers keep the low vec_w bits.
  function automatic logic signed [31:0] sat_to_vec(input logic signed [31:0] value,
                                                    input int vec_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (vec_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (vec_w - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/vad_hangover.sv
// Voice-activity hangover: vad_out rises the cycle after vad_in is seen and
// falls exactly HANG_CYC cycles after the last cycle vad_in was high.
module vad_hangover
  import dnn_collect_pkg::*;
#(
  parameter int HANG_CYC = 3000000,
  parameter int HCNT_W   = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic vad_in,
  output logic vad_out
);

  logic [0:0]        r_state;
  logic [HCNT_W-1:0] r_cnt;

  // IDLE/ACTIVE state machine with a low-time counter that expires the hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= VAD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        VAD_IDLE: begin
          r_cnt <= '0;
          if (vad_in) r_state <= VAD_ACTIVE;
        end
        default: begin
          if (vad_in) begin
            r_cnt <= '0;
          end else if (r_cnt == HCNT_W'(HANG_CYC - 1)) begin
            r_cnt   <= '0;
            r_state <= VAD_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign vad_out = (r_state == VAD_ACTIVE);

endmodule

// File: rtl/dnn_frame_collector.sv
// Packs the streamed per-class DNN scores into one frame vector, tracks the
// per-frame arg-max, and publishes completed frames with a one-cycle strobe.
// Build option: define DNN_COLLECT_SERIAL_EN to add a bit-serial readout of
// frame_vec on ser_bit/ser_sync; otherwise both outputs are tied low.
module dnn_frame_collector
  import dnn_collect_pkg::*;
#(
  parameter int IN_W     = DNN_IN_W,
  parameter int VEC_W    = DNN_VEC_W,
  parameter int NUM_OUT  = DNN_NUM_OUT,
  parameter int IDX_W    = 6,
  parameter int HANG_CYC = 3000000,
  parameter int HCNT_W   = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   dnn_in,
  input  logic                     dnn_dv,
  input  logic                     frame_clr,
  input  logic                     vad_in,
  output logic [NUM_OUT*VEC_W-1:0] frame_vec,
  output logic                     frame_dv,
  output logic [IDX_W-1:0]         best_idx,
  output logic [VEC_W-1:0]         best_score,
  output logic                     vad_out,
  output logic                     ser_bit,
  output logic                     ser_sync
);

  localparam int FRAME_W = NUM_OUT * VEC_W;

  logic [IDX_W-1:0]        r_idx;
  logic [FRAME_W-1:0]      r_asm;
  logic signed [VEC_W-1:0] r_max;
  logic [IDX_W-1:0]        r_max_idx;

  logic signed [31:0]      w_in_ext;
  logic signed [VEC_W-1:0] w_score;
  logic                    w_take;
  logic                    w_last;
  logic [FRAME_W-1:0]      w_asm_next;

  assign w_in_ext = 32'(dnn_in);
  assign w_score  = VEC_W'(sat_to_vec(w_in_ext, VEC_W));
  // Slot 0 always seeds the max; later slots replace it only when strictly
  // larger, so ties keep the lower class index.
  assign w_take   = (r_idx == '0) || (w_score > r_max);
  assign w_last   = (r_idx == IDX_W'(NUM_OUT - 1));

  // Assembly buffer with the incoming score dropped into the current slot.
  // NOTE: the default copy comes first so every bit is assigned on every
  // path and no latch is inferred.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[r_idx*VEC_W +: VEC_W] = w_score;
  end

  // Slot assembly, running arg-max and publication of completed frames.
  // NOTE: the assembly buffer is wide registers rather than a RAM, so it
  // can and does take the synchronous reset along with the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_asm      <= '0;
      r_max      <= '0;
      r_max_idx  <= '0;
      frame_vec  <= '0;
      frame_dv   <= 1'b0;
      best_idx   <= '0;
      best_score <= '0;
    end else begin
      frame_dv <= 1'b0;
      if (frame_clr) begin
        r_idx     <= '0;
        r_max     <= '0;
        r_max_idx <= '0;
      end else if (dnn_dv) begin
        r_asm <= w_asm_next;
        if (w_take) begin
          r_max     <= w_score;
          r_max_idx <= r_idx;
        end
        if (w_last) begin
          r_idx      <= '0;
          frame_vec  <= w_asm_next;
          frame_dv   <= 1'b1;
          best_idx   <= w_take ? r_idx : r_max_idx;
          best_score <= w_take ? w_score : r_max;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  vad_hangover #(
    .HANG_CYC (HANG_CYC),
    .HCNT_W   (HCNT_W)
  ) u_vad_hangover (
    .clk     (clk),
    .reset   (reset),
    .vad_in  (vad_in),
    .vad_out (vad_out)
  );

`ifdef DNN_COLLECT_SERIAL_EN
  localparam int PTR_W = $clog2(FRAME_W);

  logic [PTR_W-1:0] r_ptr;

  // Free-running bit pointer walking frame_vec LSB first, with a marker on bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      ser_bit  <= 1'b0;
      ser_sync <= 1'b0;
    end else begin
      ser_bit  <= frame_vec[r_ptr];
      ser_sync <= (r_ptr == '0);
      r_ptr    <= (r_ptr == PTR_W'(FRAME_W - 1)) ? '0 : r_ptr + 1'b1;
    end
  end
`else
  assign ser_bit  = 1'b0;
  assign ser_sync = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_frame_collector.sv
// Self-checking bench for dnn_frame_collector with a small configuration
// (4 classes of 11 bits, 10-cycle VAD hangover).
module tb_dnn_frame_collector;

  localparam int IN_W     = 22;
  localparam int VEC_W    = 11;
  localparam int NUM_OUT  = 4;
  localparam int IDX_W    = 2;
  localparam int HANG_CYC = 10;
  localparam int HCNT_W   = 4;
  localparam int FW       = NUM_OUT * VEC_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] dnn_in;
  logic                   dnn_dv;
  logic                   frame_clr;
  logic                   vad_in;
  logic [FW-1:0]          frame_vec;
  logic                   frame_dv;
  logic [IDX_W-1:0]       best_idx;
  logic [VEC_W-1:0]       best_score;
  logic                   vad_out;
  logic                   ser_bit;
  logic                   ser_sync;

  dnn_frame_collector #(
    .IN_W(IN_W), .VEC_W(VEC_W), .NUM_OUT(NUM_OUT), .IDX_W(IDX_W),
    .HANG_CYC(HANG_CYC), .HCNT_W(HCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .dnn_in(dnn_in), .dnn_dv(dnn_dv),
    .frame_clr(frame_clr), .vad_in(vad_in), .frame_vec(frame_vec),
    .frame_dv(frame_dv), .best_idx(best_idx), .best_score(best_score),
    .vad_out(vad_out), .ser_bit(ser_bit), .ser_sync(ser_sync)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: collected scores of the open frame, last
  // published frame, and the cycle of the most recent high vad_in.
  int            m_q[$];
  logic [FW-1:0] m_vec;
  int            m_idx;
  int            m_score;
  logic          m_dv;
  longint        m_cyc;
  longint        m_last_hi;
  bit            m_hi_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    int hi;
    int lo;
    hi = (1 << (VEC_W - 1)) - 1;
    lo = -(1 << (VEC_W - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [VEC_W-1:0] enc(input int v);
    return VEC_W'(v);
  endfunction

  function automatic logic [FW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [FW-1:0] r;
    r = '0;
    r[0*VEC_W +: VEC_W] = enc(a);
    r[1*VEC_W +: VEC_W] = enc(b);
    r[2*VEC_W +: VEC_W] = enc(c);
    r[3*VEC_W +: VEC_W] = enc(d);
    return r;
  endfunction

  // One clock: drive inputs, advance past the edge, update the model, compare.
  task automatic step(input logic rst, input logic dv, input int din,
                      input logic clr, input logic vad);
    logic exp_vad;
    reset     = rst;
    dnn_dv    = dv;
    dnn_in    = IN_W'(din);
    frame_clr = clr;
    vad_in    = vad;
    @(posedge clk);
    #1;
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_vec      = '0;
      m_idx      = 0;
      m_score    = 0;
      m_dv       = 1'b0;
      m_hi_valid = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (clr) begin
        m_q.delete();
      end else if (dv) begin
        m_q.push_back(sat(din));
        if (m_q.size() == NUM_OUT) begin
          m_idx   = 0;
          m_score = m_q[0];
          for (int k = 0; k < NUM_OUT; k++) begin
            m_vec[k*VEC_W +: VEC_W] = enc(m_q[k]);
            if (m_q[k] > m_score) begin
              m_score = m_q[k];
              m_idx   = k;
            end
          end
          m_dv = 1'b1;
          m_q.delete();
        end
      end
      if (vad) begin
        m_hi_valid = 1'b1;
        m_last_hi  = m_cyc;
      end
    end
    exp_vad = m_hi_valid && ((m_cyc - m_last_hi) < HANG_CYC);
    check("model frame_dv",   64'(frame_dv),   64'(m_dv));
    check("model frame_vec",  64'(frame_vec),  64'(m_vec));
    check("model best_idx",   64'(best_idx),   64'(m_idx));
    check("model best_score", 64'(best_score), 64'(enc(m_score)));
    check("model vad_out",    64'(vad_out),    64'(exp_vad));
`ifndef DNN_COLLECT_SERIAL_EN
    check("ser_bit tied",  64'(ser_bit),  64'(0));
    check("ser_sync tied", 64'(ser_sync), 64'(0));
`endif
  endtask

  typedef struct {
    logic          dv;
    int            din;
    logic          clr;
    logic          e_dv;
    logic [FW-1:0] e_vec;
    int            e_idx;
    int            e_score;
  } vec_t;

  localparam int N_TBL = 16;
  vec_t tbl[N_TBL];

  initial begin
    logic [FW-1:0] v0;
    logic [FW-1:0] v1;
    logic [FW-1:0] v2;
    logic [FW-1:0] v3;
    int            pulses;
    int            fall_at;

    m_q.delete();
    m_vec = '0; m_idx = 0; m_score = 0; m_dv = 1'b0;
    m_cyc = 0; m_last_hi = 0; m_hi_valid = 1'b0;

    v0 = '0;
    v1 = pack(5, -3, 100, 7);
    v2 = pack(1023, -1024, 1023, 0);
    v3 = pack(1, 2, 3, 4);
    // Frame 1: plain arg-max. Frame 2: saturation and a tie at the max.
    // Frame 3: a coincident frame_clr+dnn_dv drops the score and restarts.
    tbl[0]  = '{1'b1,     5, 1'b0, 1'b0, v0, 0,    0};
    tbl[1]  = '{1'b1,    -3, 1'b0, 1'b0, v0, 0,    0};
    tbl[2]  = '{1'b1,   100, 1'b0, 1'b0, v0, 0,    0};
    tbl[3]  = '{1'b1,     7, 1'b0, 1'b1, v1, 2,  100};
    tbl[4]  = '{1'b0,     0, 1'b0, 1'b0, v1, 2,  100};
    tbl[5]  = '{1'b1,  5000, 1'b0, 1'b0, v1, 2,  100};
    tbl[6]  = '{1'b1, -5000, 1'b0, 1'b0, v1, 2,  100};
    tbl[7]  = '{1'b1,  1023, 1'b0, 1'b0, v1, 2,  100};
    tbl[8]  = '{1'b1,     0, 1'b0, 1'b1, v2, 0, 1023};
    tbl[9]  = '{1'b0,     0, 1'b0, 1'b0, v2, 0, 1023};
    tbl[10] = '{1'b1,     9, 1'b0, 1'b0, v2, 0, 1023};
    tbl[11] = '{1'b1,    50, 1'b1, 1'b0, v2, 0, 1023};
    tbl[12] = '{1'b1,     1, 1'b0, 1'b0, v2, 0, 1023};
    tbl[13] = '{1'b1,     2, 1'b0, 1'b0, v2, 0, 1023};
    tbl[14] = '{1'b1,     3, 1'b0, 1'b0, v2, 0, 1023};
    tbl[15] = '{1'b1,     4, 1'b0, 1'b1, v3, 3,    4};

    // Reset state.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 77, 1'b0, 1'b1);
    check("reset frame_vec",  64'(frame_vec),  64'(0));
    check("reset frame_dv",   64'(frame_dv),   64'(0));
    check("reset best_idx",   64'(best_idx),   64'(0));
    check("reset best_score", 64'(best_score), 64'(0));
    check("reset vad_out",    64'(vad_out),    64'(0));

    // Table vectors.
    for (int i = 0; i < N_TBL; i++) begin
      step(1'b0, tbl[i].dv, tbl[i].din, tbl[i].clr, 1'b0);
      check($sformatf("tbl[%0d] frame_dv", i),   64'(frame_dv),   64'(tbl[i].e_dv));
      check($sformatf("tbl[%0d] frame_vec", i),  64'(frame_vec),  64'(tbl[i].e_vec));
      check($sformatf("tbl[%0d] best_idx", i),   64'(best_idx),   64'(tbl[i].e_idx));
      check($sformatf("tbl[%0d] best_score", i), 64'(best_score), 64'(enc(tbl[i].e_score)));
    end

    // Gaps and abort: two scores, abort, then 1,2,3,4 separated by gaps.
    pulses = 0;
    step(1'b0, 1'b1, 600, 1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b0, 0,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b1, 700, 1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b0, 0,   1'b1, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b1, 1,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b0, 0,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b0, 0,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b1, 2,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b1, 3,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b0, 0,   1'b0, 1'b0); pulses += int'(frame_dv);
    step(1'b0, 1'b1, 4,   1'b0, 1'b0); pulses += int'(frame_dv);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 1'b0, 1'b0); pulses += int'(frame_dv);
    end
    check("abort frame_dv count", 64'(pulses),    64'(1));
    check("abort frame_vec",      64'(frame_vec), 64'(v3));

    // VAD hangover: three high cycles, then measure the fall.
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("vad rise", 64'(vad_out), 64'(1));
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    fall_at = -1;
    for (int k = 1; k <= 3 * HANG_CYC && fall_at < 0; k++) begin
      step(1'b0, 1'b0, 0, 1'b0, 1'b0);
      if (!vad_out) fall_at = k;
    end
    check("vad fall delay", 64'(fall_at), 64'(HANG_CYC));

    // Re-pulse on the terminal-count cycle extends by a full hangover.
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < HANG_CYC - 1; k++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("vad held before re-pulse", 64'(vad_out), 64'(1));
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("vad held at re-pulse", 64'(vad_out), 64'(1));
    fall_at = -1;
    for (int k = 1; k <= 3 * HANG_CYC && fall_at < 0; k++) begin
      step(1'b0, 1'b0, 0, 1'b0, 1'b0);
      if (!vad_out) fall_at = k;
    end
    check("vad re-pulse fall delay", 64'(fall_at), 64'(HANG_CYC));

    // Reset in the middle of a frame.
    step(1'b0, 1'b1, 11, 1'b0, 1'b1);
    step(1'b0, 1'b1, 22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0,  1'b0, 1'b0);
    check("midreset frame_vec",  64'(frame_vec),  64'(0));
    check("midreset best_idx",   64'(best_idx),   64'(0));
    check("midreset best_score", 64'(best_score), 64'(0));
    check("midreset vad_out",    64'(vad_out),    64'(0));
    step(1'b0, 1'b1, 40, 1'b0, 1'b0);
    step(1'b0, 1'b1, -7, 1'b0, 1'b0);
    check("midreset no early dv", 64'(frame_dv), 64'(0));
    step(1'b0, 1'b1, 40, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3,  1'b0, 1'b0);
    check("midreset frame_dv",   64'(frame_dv),   64'(1));
    check("midreset new vec",    64'(frame_vec),  64'(pack(40, -7, 40, 3)));
    check("midreset tie idx",    64'(best_idx),   64'(0));
    check("midreset best_score", 64'(best_score), 64'(enc(40)));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r_rst;
      logic r_dv;
      logic r_clr;
      logic r_vad;
      int   r_din;
      r_rst = ($urandom_range(0, 149) == 0);
      r_dv  = ($urandom_range(0, 2) != 0);
      r_clr = ($urandom_range(0, 24) == 0);
      r_vad = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        r_din = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      else
        r_din = int'($urandom_range(0, 3000)) - 1500;
      step(r_rst, r_dv, r_din, r_clr, r_vad);
    end

`ifdef DNN_COLLECT_SERIAL_EN
    // Serial readout: locate the marker, then two full frames of bits.
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 2 * FW && !found; k++) begin
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        if (ser_sync) found = 1'b1;
      end
      check("ser_sync found", 64'(found), 64'(1));
      if (found) begin
        for (int f = 0; f < 2; f++) begin
          for (int b = 0; b < FW; b++) begin
            check($sformatf("ser_bit[%0d]", b), 64'(ser_bit), 64'(m_vec[b]));
            check("ser_sync period", 64'(ser_sync), 64'(b == 0));
            step(1'b0, 1'b0, 0, 1'b0, 1'b0);
          end
        end
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
